// File: rtl/r4mdc_out_reorder.sv
// Output reordering buffer for the radix-4 MDC FFT.
// Two ping-pong banks of N complex words: the last butterfly's four lanes are
// written into one bank (optionally at digit-reversed addresses) while the
// other bank is read out in natural address order, one sample per cycle.
module r4mdc_out_reorder #(
    parameter int WL = 16,
    parameter int N  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in1_r,
    input  logic [WL-1:0] in1_i,
    input  logic [WL-1:0] in2_r,
    input  logic [WL-1:0] in2_i,
    input  logic [WL-1:0] in3_r,
    input  logic [WL-1:0] in3_i,
    input  logic [WL-1:0] in4_r,
    input  logic [WL-1:0] in4_i,
    input  logic          digit_rev_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_r,
    output logic [WL-1:0] out_i,
    output logic          out_first,
    output logic          out_last
);
    localparam int LOG4N = $clog2(N) / 2;
    localparam int BEATS = N / 4;
    localparam int AW    = 2 * LOG4N;
    localparam int BW    = AW - 2;
    localparam int DW    = 2 * WL;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // Bank b occupies words b*N .. b*N+N-1; word = {real, imag}.
    logic [DW-1:0] r_mem [0:2*N-1];

    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic          r_fetch_bank;
    logic [BW-1:0] r_beat;
    logic [AW-1:0] r_fetch_addr;
    logic          r_mode_lat;
    logic          r_commit;
    logic          r_commit_bank;
    logic          r_out_valid;
    logic [WL-1:0] r_out_r;
    logic [WL-1:0] r_out_i;
    logic          r_out_first;
    logic          r_out_last;

    logic          w_accept;
    logic          w_mode;
    logic          w_fetch;
    logic          w_xfer_last;
    logic [DW-1:0] w_rd_word;
    logic [DW-1:0] w_lane  [4];
    logic [AW-1:0] w_waddr [4];

    // Reverse the LOG4N base-4 digits of a position.
    function automatic logic [AW-1:0] digitrev4(input logic [AW-1:0] p);
        logic [AW-1:0] r;
        r = '0;
        for (int d = 0; d < LOG4N; d++) begin
            r[2*d +: 2] = p[2*(LOG4N-1-d) +: 2];
        end
        return r;
    endfunction

    assign w_lane[0] = {in1_r, in1_i};
    assign w_lane[1] = {in2_r, in2_i};
    assign w_lane[2] = {in3_r, in3_i};
    assign w_lane[3] = {in4_r, in4_i};

    assign in_ready    = ~r_full[r_wr_bank];
    assign w_accept    = in_valid & in_ready;
    // Beat 0 uses the live mode input; later beats use the value latched on beat 0.
    assign w_mode      = (r_beat == '0) ? digit_rev_en : r_mode_lat;
    assign w_fetch     = r_full[r_fetch_bank] & (~r_out_valid | out_ready);
    assign w_xfer_last = r_out_valid & out_ready & r_out_last;
    assign w_rd_word   = r_mem[{r_fetch_bank, r_fetch_addr}];

    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;
    assign out_i     = r_out_i;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;

    // Write address for each lane of the current beat: position p = 4*beat + lane.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            w_waddr[l] = w_mode ? digitrev4({r_beat, 2'(l)}) : {r_beat, 2'(l)};
        end
    end

    // Bank storage: all four lanes of an accepted beat land in the write bank.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int l = 0; l < 4; l++) begin
                r_mem[{r_wr_bank, w_waddr[l]}] <= w_lane[l];
            end
        end
    end

    // Write-side sequencing and bank full flags; a completed bank is marked
    // full one edge after its final beat is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full        <= 2'b00;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_beat        <= '0;
            r_mode_lat    <= 1'b0;
            r_commit      <= 1'b0;
            r_commit_bank <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (w_accept) begin
                if (r_beat == '0) begin
                    r_mode_lat <= digit_rev_en;
                end
                if (r_beat == LAST_BEAT) begin
                    r_beat        <= '0;
                    r_wr_bank     <= ~r_wr_bank;
                    r_commit      <= 1'b1;
                    r_commit_bank <= r_wr_bank;
                end else begin
                    r_beat <= r_beat + BW'(1);
                end
            end
            // The committing bank is never the one being drained, so both may act at once.
            if (r_commit) begin
                r_full[r_commit_bank] <= 1'b1;
            end
            if (w_xfer_last) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

    // Read side: fetch addresses 0..N-1 into the registered output stage,
    // holding the stage while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_bank <= 1'b0;
            r_fetch_addr <= '0;
            r_out_valid  <= 1'b0;
            r_out_r      <= '0;
            r_out_i      <= '0;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
        end else if (w_fetch) begin
            r_out_valid <= 1'b1;
            r_out_r     <= w_rd_word[DW-1:WL];
            r_out_i     <= w_rd_word[WL-1:0];
            r_out_first <= (r_fetch_addr == '0);
            r_out_last  <= (r_fetch_addr == LAST_ADDR);
            if (r_fetch_addr == LAST_ADDR) begin
                r_fetch_addr <= '0;
                r_fetch_bank <= ~r_fetch_bank;
            end else begin
                r_fetch_addr <= r_fetch_addr + AW'(1);
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_r4mdc_out_reorder.sv
// Directed bench for r4mdc_out_reorder: N=16 and N=64 instances.
`timescale 1ns/1ps
module tb_r4mdc_out_reorder;
    localparam int WL = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // N=16 instance
    logic          in_valid, in_ready, digit_rev_en;
    logic [WL-1:0] in_r [4];
    logic [WL-1:0] in_i [4];
    logic          out_valid, out_ready, out_first, out_last;
    logic [WL-1:0] out_r, out_i;

    // N=64 instance
    logic          in_valid_b, in_ready_b, digit_rev_en_b;
    logic [WL-1:0] in_r_b [4];
    logic [WL-1:0] in_i_b [4];
    logic          out_valid_b, out_ready_b, out_first_b, out_last_b;
    logic [WL-1:0] out_r_b, out_i_b;

    r4mdc_out_reorder #(.WL(WL), .N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1_r(in_r[0]), .in1_i(in_i[0]), .in2_r(in_r[1]), .in2_i(in_i[1]),
        .in3_r(in_r[2]), .in3_i(in_i[2]), .in4_r(in_r[3]), .in4_i(in_i[3]),
        .digit_rev_en(digit_rev_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_first(out_first), .out_last(out_last)
    );

    r4mdc_out_reorder #(.WL(WL), .N(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in1_r(in_r_b[0]), .in1_i(in_i_b[0]), .in2_r(in_r_b[1]), .in2_i(in_i_b[1]),
        .in3_r(in_r_b[2]), .in3_i(in_i_b[2]), .in4_r(in_r_b[3]), .in4_i(in_i_b[3]),
        .digit_rev_en(digit_rev_en_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_r(out_r_b), .out_i(out_i_b), .out_first(out_first_b), .out_last(out_last_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    typedef struct {
        logic [WL-1:0] r;
        logic [WL-1:0] i;
        logic          f;
        logic          l;
        int            cyc;
    } xfer_t;

    xfer_t q16[$];
    xfer_t q64[$];

    // Natural-order index k holds position digitrev4(k); written out digit by digit.
    function automatic int rev16(input int a);
        return (a % 4) * 4 + a / 4;
    endfunction

    function automatic int rev64(input int a);
        return (a % 4) * 16 + ((a / 4) % 4) * 4 + a / 16;
    endfunction

    // Capture transfers and check that a stalled output holds still.
    logic        hold_pend = 1'b0;
    logic [33:0] hold_val;
    always @(negedge clk) begin
        if (hold_pend)
            chk("stall_hold", {out_valid, out_r, out_i, out_first, out_last}, {1'b1, hold_val});
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_r, out_i, out_first, out_last};
        if (out_valid && out_ready) q16.push_back('{out_r, out_i, out_first, out_last, cyc});
        if (out_valid_b && out_ready_b) q64.push_back('{out_r_b, out_i_b, out_first_b, out_last_b, cyc});
    end

    int stall0;

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int base, input int b);
        for (int l = 0; l < 4; l++) begin
            in_r[l] = WL'(base + 4 * b + l);
            in_i[l] = WL'(-(base + 4 * b + l));
        end
    endtask

    // One N=16 frame; value at position p is base+p. flip toggles the mode after beat 0.
    task automatic send16(input int base, input bit rev, input bit flip);
        for (int b = 0; b < 4; b++) begin
            int guard;
            guard = 0;
            in_valid = 1'b1;
            set_beat(base, b);
            digit_rev_en = (b == 0 || !flip) ? rev : !rev;
            @(negedge clk);
            while (!in_ready && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) chk("in_ready_timeout", 64'(in_ready), 64'd1);
            if (b == 0) stall0 = guard;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_q16(input int n);
        int g;
        g = 0;
        while (q16.size() < n && g < 400) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
        chk("q16_count", 64'(q16.size()), 64'(n));
    endtask

    task automatic check_frame16(input int start, input int base, input bit rev);
        for (int k = 0; k < 16; k++) begin
            int v;
            v = base + (rev ? rev16(k) : k);
            if (start + k < q16.size())
                chk($sformatf("f%0h_k%0d", base, k),
                    {q16[start+k].r, q16[start+k].i, q16[start+k].f, q16[start+k].l},
                    {WL'(v), WL'(-v), (k == 0), (k == 15)});
            else
                chk($sformatf("f%0h_k%0d_missing", base, k), 64'(q16.size()), 64'(start + k + 1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; digit_rev_en = 1'b0; out_ready = 1'b1;
        in_valid_b = 1'b0; digit_rev_en_b = 1'b0; out_ready_b = 1'b1;
        for (int l = 0; l < 4; l++) begin
            in_r[l] = '0; in_i[l] = '0; in_r_b[l] = '0; in_i_b[l] = '0;
        end

        @(negedge clk);
        chk("reset_state", {in_ready, out_valid, out_r, out_i, out_first, out_last}, {1'b1, 35'd0});
        chk("reset_state64", {in_ready_b, out_valid_b}, 2'b10);
        align();
        rst_n = 1'b1;

        // 1: digit reversal, latency
        align();
        q16.delete();
        send16(0, 1'b1, 1'b0);
        @(negedge clk); chk("lat_edge0", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_edge1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_edge2", {out_valid, out_first}, 2'b11);
        wait_q16(16);
        check_frame16(0, 0, 1'b1);

        // 2: position order, with and without a mid-frame mode toggle
        align();
        q16.delete();
        send16(0, 1'b0, 1'b0);
        wait_q16(16);
        check_frame16(0, 0, 1'b0);
        align();
        q16.delete();
        send16('h40, 1'b0, 1'b1);
        wait_q16(16);
        check_frame16(0, 'h40, 1'b0);

        // 3: three frames back to back
        align();
        q16.delete();
        send16('h100, 1'b1, 1'b0);
        send16('h200, 1'b1, 1'b0);
        chk("rdy_low_after_f2", 64'(in_ready), 64'd0);
        send16('h300, 1'b1, 1'b0);
        chk("f3_stall_cycles", 64'(stall0), 64'd14);
        wait_q16(48);
        check_frame16(0, 'h100, 1'b1);
        check_frame16(16, 'h200, 1'b1);
        check_frame16(32, 'h300, 1'b1);
        if (q16.size() == 48) chk("gapless", 64'(q16[47].cyc - q16[0].cyc), 64'd47);

        // 4: out_ready pattern 1,0,0,1
        align();
        q16.delete();
        fork
            send16('h400, 1'b1, 1'b0);
            begin
                for (int c = 0; c < 80; c++) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_q16(16);
        check_frame16(0, 'h400, 1'b1);

        // 5: reset after two beats
        align();
        q16.delete();
        in_valid = 1'b1; digit_rev_en = 1'b1;
        set_beat('h500, 0); align();
        set_beat('h500, 1); align();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("in_reset_now", {in_ready, out_valid, out_r, out_i, out_first, out_last}, {1'b1, 35'd0});
        repeat (2) @(negedge clk);
        chk("in_reset_held", {in_ready, out_valid, out_r, out_i, out_first, out_last}, {1'b1, 35'd0});
        align();
        rst_n = 1'b1;
        send16('h600, 1'b1, 1'b0);
        wait_q16(16);
        check_frame16(0, 'h600, 1'b1);

        // 6: N=64 digit reversal
        align();
        q64.delete();
        for (int b = 0; b < 16; b++) begin
            int guard;
            guard = 0;
            in_valid_b = 1'b1;
            digit_rev_en_b = 1'b1;
            for (int l = 0; l < 4; l++) begin
                in_r_b[l] = WL'(4 * b + l);
                in_i_b[l] = WL'(-(4 * b + l));
            end
            @(negedge clk);
            while (!in_ready_b && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) chk("in_ready64_timeout", 64'(in_ready_b), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid_b = 1'b0;
        begin
            int g;
            g = 0;
            while (q64.size() < 64 && g < 400) begin
                @(negedge clk);
                g++;
            end
            repeat (4) @(negedge clk);
        end
        chk("q64_count", 64'(q64.size()), 64'd64);
        for (int k = 0; k < 64; k++) begin
            if (k < q64.size())
                chk($sformatf("n64_k%0d", k), {q64[k].r, q64[k].i, q64[k].f, q64[k].l},
                    {WL'(rev64(k)), WL'(-rev64(k)), (k == 0), (k == 63)});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
